// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and default constants for the pipeline hazard controller.
//   hz_state_t      : controller FSM state (RUN / MEM_WAIT / TIMEOUT)
//   DEF_REG_W       : default register-address width
//   DEF_MEM_TIMEOUT : default maximum memory-wait stall length
//   DEF_CNT_W       : default performance-counter width
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam int DEF_REG_W       = 4;
    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the 5-stage pipeline and the hazard controller.
//   Pipeline -> controller : rs1D, rs2D, rdE, regwriteE, memtoregE,
//                            branch_takenE, mem_reqM, mem_ackM
//   Controller -> pipeline : stallF, stallD, stallE, stallM,
//                            flushD, flushE, flushW
// Modports:
//   master : pipeline side (drives hazard sources, receives stall/flush)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
);
    logic [REG_W-1:0] rs1D;
    logic [REG_W-1:0] rs2D;
    logic [REG_W-1:0] rdE;
    logic             regwriteE;
    logic             memtoregE;
    logic             branch_takenE;
    logic             mem_reqM;
    logic             mem_ackM;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;

    modport master (
        output rs1D, rs2D, rdE, regwriteE, memtoregE, branch_takenE,
               mem_reqM, mem_ackM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );

    modport slave (
        input  rs1D, rs2D, rdE, regwriteE, memtoregE, branch_takenE,
               mem_reqM, mem_ackM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   inc   : count one event on this edge
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for a 5-stage F/D/E/M/W pipeline. Handles load-use
// bubbles, taken-branch flushes and multi-cycle memory waits guarded by a
// timeout watchdog. Stall/flush outputs are decoded combinationally from the
// registered FSM state and the current inputs (same-cycle effect).
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset; forces all outputs low
//   hz           : hazard_ctrl_if.slave (hazard sources in, stall/flush out)
//   mem_timeout  : sticky watchdog error, cleared only by reset
//   stall_cycles : saturating count of cycles with stallF
//   flush_events : saturating count of cycles with flushD|flushE
// Optional feature: define HAZARD_CTRL_PERF_EN to build the performance
// counters; otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_timeout_reg;

    logic lu;
    logic mem_miss;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign lu = hz.memtoregE & hz.regwriteE & (hz.rdE != '0) &
                ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));

    // A request acked in its own cycle is a zero-wait access.
    assign mem_miss = hz.mem_reqM & ~hz.mem_ackM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_miss) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    // An ack on the last allowed cycle still wins over the trap.
                    if (hz.mem_ackM) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg       <= TIMEOUT;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                TIMEOUT: begin
                    mem_timeout_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Reset is folded in here so outputs drop immediately, without a clock edge.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            case (state_reg)
                RUN: begin
                    if (mem_miss) begin
                        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                        flush_w = 1'b1;
                    end else if (hz.branch_takenE) begin
                        // The dependent instruction in D is flushed anyway,
                        // so a concurrent load-use needs no bubble.
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MEM_WAIT, TIMEOUT: begin
                    // D and E are frozen; branch and load-use are re-evaluated
                    // once the pipeline is released.
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.stallF = stall_f;
    assign hz.stallD = stall_d;
    assign hz.stallE = stall_e;
    assign hz.stallM = stall_m;
    assign hz.flushD = flush_d;
    assign hz.flushE = flush_e;
    assign hz.flushW = flush_w;

    assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_CTRL_PERF_EN
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = stall_f;
    assign cnt_inc[1] = flush_d | flush_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(
                .WIDTH (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cycles = cnt_val[0];
    assign flush_events = cnt_val[1];
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
